// File: rtl/branch_decode.sv
// LEGv8 branch decoder: registers B/CBZ/CBNZ decode with a valid/ready output and shadow-flush FSM.
// Optional delivered-branch statistics counter is built when BRANCH_DECODE_STATS_EN is defined.
module branch_decode #(
  parameter int BITSIZE     = 64,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               taken,
  output logic [BITSIZE-1:0] shiftleft2,
  output logic               branch,
  output logic               uncondbranch,
  output logic               zinvert,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        branch_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] DEPTH = 3'(FLUSH_DEPTH);

  state_t             state;
  state_t             state_next;
  logic [2:0]         cnt;
  logic [2:0]         cnt_next;
  logic               accept;
  logic               issue;
  logic               dec_b;
  logic               dec_cb;
  logic [BITSIZE-1:0] dec_off;

  // Shadow instructions are always drained while flushing, regardless of the output stage.
  assign instr_ready = (state == FLUSH) || !out_valid || out_ready;
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && (state == RUN) && !taken;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    dec_b   = (instr[31:26] == 6'b000101);
    dec_cb  = (instr[31:25] == 7'b1011010);
    dec_off = '0;
    if (dec_b) begin
      dec_off = {{(BITSIZE-26){instr[25]}}, instr[25:0]} << 2;
    end else if (dec_cb) begin
      dec_off = {{(BITSIZE-19){instr[23]}}, instr[23:5]} << 2;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (taken) begin
      state_next = FLUSH;
      cnt_next   = DEPTH;
    end else begin
      case (state)
        RUN: begin
          if (issue && dec_b) begin
            state_next = FLUSH;
            cnt_next   = DEPTH;
          end
        end
        FLUSH: begin
          if (accept) begin
            cnt_next = cnt - 3'd1;
            if (cnt_next == 3'd0) state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A redirect kills whatever sits in the output stage; otherwise it holds until consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      branch       <= 1'b0;
      uncondbranch <= 1'b0;
      zinvert      <= 1'b0;
      shiftleft2   <= '0;
    end else if (taken) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid    <= 1'b1;
      branch       <= dec_cb;
      uncondbranch <= dec_b;
      zinvert      <= dec_cb && instr[24];
      shiftleft2   <= dec_off;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BRANCH_DECODE_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 16'd0;
    end else if (out_valid && out_ready && (branch || uncondbranch) && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign branch_count = count_q;
`else
  assign branch_count = 16'd0;
`endif

endmodule

// File: tb/tb_branch_decode.sv
// Self-checking bench for branch_decode: scoreboarded decode, flush, redirect, hold and reset scenarios.
module tb_branch_decode;

  localparam int BITSIZE = 64;
  localparam logic [31:0] ADD = 32'h8B020020;
`ifdef BRANCH_DECODE_STATS_EN
  localparam logic [15:0] EXP_CNT = 16'd3;
`else
  localparam logic [15:0] EXP_CNT = 16'd0;
`endif

  typedef struct {
    logic        br;
    logic        ub;
    logic        zi;
    logic [63:0] off;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic        iv;
    logic        tk;
    logic        rdy;
    logic        dlv;
  } stim_t;

  logic               clk;
  logic               rst;
  logic [31:0]        ins;
  logic               iv;
  logic               instr_ready;
  logic               tk;
  logic [BITSIZE-1:0] shiftleft2;
  logic               branch;
  logic               uncondbranch;
  logic               zinvert;
  logic               out_valid;
  logic               ordy;
  logic [15:0]        branch_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  branch_decode #(.BITSIZE(BITSIZE), .FLUSH_DEPTH(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (ins),
    .instr_valid  (iv),
    .instr_ready  (instr_ready),
    .taken        (tk),
    .shiftleft2   (shiftleft2),
    .branch       (branch),
    .uncondbranch (uncondbranch),
    .zinvert      (zinvert),
    .out_valid    (out_valid),
    .out_ready    (ordy),
    .branch_count (branch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  function automatic logic [31:0] mk_cb(input logic nz, input logic [18:0] imm);
    return {7'b1011010, nz, imm, 5'd3};
  endfunction

  // Reference decode: immediates are converted to signed integers and scaled by 4.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   v;
    e = '{br: 1'b0, ub: 1'b0, zi: 1'b0, off: 64'd0};
    if (w[31:26] == 6'b000101) begin
      e.ub = 1'b1;
      v = int'({6'd0, w[25:0]});
      if (w[25]) v = v - (1 << 26);
      e.off = 64'(longint'(v) * 4);
    end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5) begin
      e.br = 1'b1;
      e.zi = (w[31:24] == 8'hB5);
      v = int'({13'd0, w[23:5]});
      if (w[23]) v = v - (1 << 19);
      e.off = 64'(longint'(v) * 4);
    end
    return e;
  endfunction

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, branch, uncondbranch, zinvert} !== 4'b0 || shiftleft2 !== 64'd0) begin
      $display("FAIL reset_outputs: got v=%b b=%b u=%b z=%b off=%h want all zero",
               out_valid, branch, uncondbranch, zinvert, shiftleft2);
    end else n_pass++;
    n_checks++;
    if (branch_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", branch_count);
    else n_pass++;
    ins = mk_b(26'h1); iv = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || uncondbranch !== 1'b0) begin
      $display("FAIL reset_held: got v=%b u=%b want 0 0", out_valid, uncondbranch);
    end else n_pass++;
    iv = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  // B, shadow ADD (discarded), CBZ back-to-back, then CBNZ, non-branch and negative CBZ.
  task automatic test_decode;
    stim_t tbl[8];
    exp_t  e;
    tbl[0] = '{mk_b(26'h3FFFFFF),      1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{ADD,                    1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{mk_cb(1'b0, 19'd26),    1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{mk_cb(1'b1, 19'd26),    1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{ADD,                    1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{mk_cb(1'b0, 19'h7FFFF), 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{ADD,                    1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{ADD,                    1'b0, 1'b0, 1'b1, 1'b0};
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ins = tbl[i].ins; iv = tbl[i].iv; tk = tbl[i].tk;
      #1;
      n_checks++;
      if (instr_ready !== tbl[i].rdy) $display("FAIL decode_ready[%0d]: got %b want %b", i, instr_ready, tbl[i].rdy);
      else n_pass++;
      if (tbl[i].dlv) sb.push_back(model(tbl[i].ins));
      @(negedge clk);
      n_checks++;
      if (sb.size() == 0) begin
        if (out_valid !== 1'b0) $display("FAIL decode_idle[%0d]: got out_valid=%b want 0", i, out_valid);
        else n_pass++;
      end else begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || branch !== e.br || uncondbranch !== e.ub || zinvert !== e.zi || shiftleft2 !== e.off)
          $display("FAIL decode_out[%0d]: got v=%b b=%b u=%b z=%b off=%h want v=1 b=%b u=%b z=%b off=%h",
                   i, out_valid, branch, uncondbranch, zinvert, shiftleft2, e.br, e.ub, e.zi, e.off);
        else n_pass++;
      end
    end
    iv = 1'b0;
  endtask

  // Redirect discards the coincident instruction; a redirect during flush reloads the counter.
  task automatic test_taken;
    stim_t tbl[6];
    exp_t  e;
    tbl[0] = '{mk_cb(1'b0, 19'd26), 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{mk_cb(1'b1, 19'd26), 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{ADD,                 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{ADD,                 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{mk_cb(1'b1, 19'd5),  1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{ADD,                 1'b0, 1'b0, 1'b1, 1'b0};
    ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ins = tbl[i].ins; iv = tbl[i].iv; tk = tbl[i].tk;
      #1;
      n_checks++;
      if (instr_ready !== tbl[i].rdy) $display("FAIL taken_ready[%0d]: got %b want %b", i, instr_ready, tbl[i].rdy);
      else n_pass++;
      if (tbl[i].dlv) sb.push_back(model(tbl[i].ins));
      @(negedge clk);
      n_checks++;
      if (sb.size() == 0) begin
        if (out_valid !== 1'b0) $display("FAIL taken_idle[%0d]: got out_valid=%b want 0", i, out_valid);
        else n_pass++;
      end else begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || branch !== e.br || uncondbranch !== e.ub || zinvert !== e.zi || shiftleft2 !== e.off)
          $display("FAIL taken_out[%0d]: got v=%b b=%b u=%b z=%b off=%h want v=1 b=%b u=%b z=%b off=%h",
                   i, out_valid, branch, uncondbranch, zinvert, shiftleft2, e.br, e.ub, e.zi, e.off);
        else n_pass++;
      end
    end
    iv = 1'b0; tk = 1'b0;
  endtask

  // Backpressure holds the output, redirect drops it, reset clears a held B mid-flush.
  task automatic test_hold;
    exp_t e;
    ordy = 1'b0; tk = 1'b0;
    ins = mk_cb(1'b1, 19'd26); iv = 1'b1;
    e = model(ins);
    @(negedge clk);
    ins = mk_cb(1'b0, 19'd5);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (instr_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b want 0", k, instr_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1 || branch !== e.br || zinvert !== e.zi || uncondbranch !== e.ub || shiftleft2 !== e.off)
        $display("FAIL hold_stable[%0d]: got v=%b b=%b z=%b off=%h want v=1 b=%b z=%b off=%h",
                 k, out_valid, branch, zinvert, shiftleft2, e.br, e.zi, e.off);
      else n_pass++;
      @(negedge clk);
    end
    iv = 1'b0; tk = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL hold_taken_drop: got out_valid=%b want 0", out_valid);
    else n_pass++;
    tk = 1'b0; ordy = 1'b1; ins = ADD; iv = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL hold_flush_discard: got out_valid=%b want 0", out_valid);
    else n_pass++;
    ordy = 1'b0; ins = mk_b(26'd7); iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || uncondbranch !== 1'b0 || shiftleft2 !== 64'd0)
      $display("FAIL hold_reset: got v=%b u=%b off=%h want 0 0 0", out_valid, uncondbranch, shiftleft2);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1; ordy = 1'b1;
    ins = mk_cb(1'b0, 19'd26); iv = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL hold_post_reset_ready: got %b want 1", instr_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || branch !== 1'b1 || zinvert !== 1'b0 || shiftleft2 !== 64'd104)
      $display("FAIL hold_post_reset_decode: got v=%b b=%b z=%b off=%h want 1 1 0 68",
               out_valid, branch, zinvert, shiftleft2);
    else n_pass++;
    iv = 1'b0;
    @(negedge clk);
  endtask

  // Three branches and two non-branches delivered, then reset lands mid-flush.
  task automatic test_stats;
    logic [31:0] seq [5];
    seq[0] = mk_cb(1'b0, 19'd26);
    seq[1] = ADD;
    seq[2] = mk_cb(1'b1, 19'd26);
    seq[3] = ADD;
    seq[4] = mk_b(26'd12);
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1; ordy = 1'b1; tk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ins = seq[i]; iv = 1'b1;
      @(negedge clk);
    end
    iv = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (branch_count !== EXP_CNT) $display("FAIL stats_count: got %0d want %0d", branch_count, EXP_CNT);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (branch_count !== 16'd0 || out_valid !== 1'b0)
      $display("FAIL stats_reset: got count=%0d v=%b want 0 0", branch_count, out_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    ins = mk_cb(1'b1, 19'd5); iv = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL stats_run_ready: got %b want 1", instr_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || branch !== 1'b1 || zinvert !== 1'b1 || shiftleft2 !== 64'd20)
      $display("FAIL stats_run_decode: got v=%b b=%b z=%b off=%h want 1 1 1 14",
               out_valid, branch, zinvert, shiftleft2);
    else n_pass++;
    iv = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; ins = 32'd0; iv = 1'b0; tk = 1'b0; ordy = 1'b1;
    test_reset;
    test_decode;
    test_taken;
    test_hold;
    test_stats;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
